mem_io_arbiter: RTL and testbench

- Shares one single-port synchronous memory (1-cycle read latency) between the multi-cycle core's instruction-fetch port (IF) and data port (DM).
- Decodes one memory-mapped IO register, mem_map_io, whose low byte drives the board LEDs.
- Sits between the multi-cycle processor and the block RAM inside mojo_top. Runs on the processor clock.

---
 rtl/mem_io_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_io_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and data ports.
// Also decodes a single memory-mapped IO register whose low byte drives the LEDs.
module mem_io_arbiter #(
    parameter int                   BUS_WIDTH  = 32,
    parameter int                   ADDR_WIDTH = 10,
    parameter logic [BUS_WIDTH-1:0] IO_ADDR    = 32'hFFFF_FFF0
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    if_req_i,
    input  logic [BUS_WIDTH-1:0]    if_addr_i,
    output logic                    if_ack_o,
    output logic [BUS_WIDTH-1:0]    if_rdata_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [BUS_WIDTH-1:0]    dm_addr_i,
    input  logic [BUS_WIDTH-1:0]    dm_wdata_i,
    input  logic [BUS_WIDTH/8-1:0]  dm_be_i,
    output logic                    dm_ack_o,
    output logic [BUS_WIDTH-1:0]    dm_rdata_o,
    output logic                    err_o,
    output logic                    mem_en_o,
    output logic [BUS_WIDTH/8-1:0]  mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [BUS_WIDTH-1:0]    mem_wdata_o,
    input  logic [BUS_WIDTH-1:0]    mem_rdata_i,
    output logic [BUS_WIDTH-1:0]    mem_map_io_o
);
    localparam int NB = BUS_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
    typedef enum logic [1:0] {K_MEM, K_IO, K_ERR} kind_e;

    state_e                 state_q, state_d;
    kind_e                  kind_q, kind_d, sel_kind;
    logic                   own_dm_q, own_dm_d;
    logic                   last_dm_q, last_dm_d;
    logic                   we_q, we_d;
    logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]          be_q, be_d;
    logic [BUS_WIDTH-1:0]   io_q, io_d;
    logic                   mem_en_q, mem_en_d;
    logic [NB-1:0]          mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [BUS_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic                   pick_dm;
    logic [BUS_WIDTH-1:0]   sel_addr;
    logic [BUS_WIDTH-1:0]   rdata_sel;
    logic                   resp;

    function automatic kind_e decode(input logic [BUS_WIDTH-1:0] a);
        if (a[1:0] != 2'b00)                  return K_ERR;
        if (a == IO_ADDR)                     return K_IO;
        if ((a >> (ADDR_WIDTH + 2)) == '0)    return K_MEM;
        return K_ERR;
    endfunction

    // Round-robin on a tie: the port that was not served last wins.
    assign pick_dm  = dm_req_i && (!if_req_i || !last_dm_q);
    assign sel_addr = pick_dm ? dm_addr_i : if_addr_i;
    assign sel_kind = decode(sel_addr);

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        own_dm_d    = own_dm_q;
        last_dm_d   = last_dm_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        io_d        = io_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    state_d  = S_ACCESS;
                    own_dm_d = pick_dm;
                    kind_d   = sel_kind;
                    we_d     = pick_dm && dm_we_i;
                    wdata_d  = dm_wdata_i;
                    be_d     = dm_be_i;
                    // Memory strobes are registered so they are live exactly during ACCESS.
                    if (sel_kind == K_MEM) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = (pick_dm && dm_we_i) ? dm_be_i : '0;
                        mem_addr_d  = sel_addr[ADDR_WIDTH+1:2];
                        mem_wdata_d = dm_wdata_i;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (kind_q == K_IO && we_q) begin
                    for (int i = 0; i < NB; i++)
                        if (be_q[i]) io_d[8*i +: 8] = wdata_q[8*i +: 8];
                end
            end
            S_RESP: begin
                state_d   = S_IDLE;
                last_dm_d = own_dm_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            kind_q      <= K_MEM;
            own_dm_q    <= 1'b0;
            last_dm_q   <= 1'b1;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            io_q        <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            own_dm_q    <= own_dm_d;
            last_dm_q   <= last_dm_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            io_q        <= io_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign resp      = (state_q == S_RESP);
    assign rdata_sel = (kind_q == K_MEM) ? mem_rdata_i :
                       (kind_q == K_IO)  ? io_q : '0;

    assign if_ack_o     = resp && !own_dm_q;
    assign dm_ack_o     = resp && own_dm_q;
    assign if_rdata_o   = if_ack_o ? rdata_sel : '0;
    assign dm_rdata_o   = dm_ack_o ? rdata_sel : '0;
    assign err_o        = resp && (kind_q == K_ERR);
    // Reset landing mid-ACCESS must not let the RAM commit the dropped write.
    assign mem_en_o     = mem_en_q && rst_n_i;
    assign mem_we_o     = mem_we_q & {NB{rst_n_i}};
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_map_io_o = io_q;
endmodule

// File: tb/tb_mem_io_arbiter.sv
// Directed bench for mem_io_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_io_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        if_ack, dm_ack, err, mem_en;
    logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata, mem_map_io;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;

    logic [31:0] ram [1024];
    int          en_cnt = 0;
    int          we_cnt = 0;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mem_io_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_be_i(dm_be), .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata), .err_o(err),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_map_io_o(mem_map_io)
    );

    initial for (int i = 0; i < 1024; i++) ram[i] = 32'h0;

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            en_cnt <= en_cnt + 1;
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_we !== 4'b0000 && mem_we !== 4'bxxxx) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One transaction from IDLE; returns ack latency (-1 on timeout), rdata and err.
    task automatic txn(input bit is_dm, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output int lat, output logic [31:0] rd, output logic e);
        lat = -1; rd = '0; e = 1'b0;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            tick();
            if (is_dm && dm_ack)  begin lat = c; rd = dm_rdata; e = err; end
            if (!is_dm && if_ack) begin lat = c; rd = if_rdata; e = err; end
        end
        dm_req = 1'b0; if_req = 1'b0;
        tick();
    endtask

    int          lat, en0, we0, if1, if2, dm1;
    logic [31:0] rd, rd_if1;
    logic        e;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10; dm_wdata = '0; dm_be = '0;

        // Reset held with a pending request
        tick(); tick();
        chk("rst_acks",  {30'h0, if_ack, dm_ack}, 32'h0);
        chk("rst_mem",   {26'h0, err, mem_en, mem_we}, 32'h0);
        chk("rst_io",    mem_map_io, 32'h0);
        chk("rst_addr",  {22'h0, mem_addr}, 32'h0);
        rst_n = 1'b1;
        chk("rel_c0_en", {31'h0, mem_en}, 32'h0);
        tick();
        chk("rel_c1_en", {31'h0, mem_en}, 32'h1);
        tick();
        chk("rel_c2_ack", {31'h0, dm_ack}, 32'h1);
        dm_req = 1'b0;
        tick();

        // Full-word store with strobe timing checked cycle by cycle
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        tick();
        chk("st_c1", {mem_en, mem_we, 17'h0, mem_addr}, {1'b1, 4'hF, 17'h0, 10'd4});
        chk("st_c1_wd", mem_wdata, 32'hDEAD_BEEF);
        chk("st_c1_ack", {31'h0, dm_ack}, 32'h0);
        tick();
        chk("st_c2", {29'h0, mem_en, dm_ack, err}, 32'h2);
        dm_req = 1'b0;
        tick();
        txn(1'b0, 1'b0, 32'h10, '0, '0, lat, rd, e);
        chk("if_lat", lat, 2);
        chk("if_rdata", rd, 32'hDEAD_BEEF);

        // Byte-enable merge: 11223344 then AABBCCDD on lanes 0 and 2
        txn(1'b1, 1'b1, 32'h14, 32'h1122_3344, 4'hF, lat, rd, e);
        txn(1'b1, 1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, lat, rd, e);
        txn(1'b1, 1'b0, 32'h14, '0, '0, lat, rd, e);
        chk("be_merge", rd, 32'h11BB_33DD);

        // Tie after reset: IF, then DM, then IF again
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h14;
        if1 = -1; if2 = -1; dm1 = -1; rd_if1 = '0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (if_ack) begin
                if (if1 < 0) begin if1 = c; rd_if1 = if_rdata; end
                else if (if2 < 0) if2 = c;
            end
            if (dm_ack && dm1 < 0) dm1 = c;
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        chk("tie_if1", if1, 2);
        chk("tie_dm1", dm1, 5);
        chk("tie_if2", if2, 8);
        chk("tie_rd", rd_if1, 32'hDEAD_BEEF);

        // IO register: byte store, then readback, no RAM activity
        en0 = en_cnt;
        txn(1'b1, 1'b1, 32'hFFFF_FFF0, 32'h1234_56A5, 4'b0001, lat, rd, e);
        chk("io_st_lat", lat, 2);
        chk("io_reg", mem_map_io, 32'h0000_00A5);
        chk("io_st_err", {31'h0, e}, 32'h0);
        txn(1'b1, 1'b0, 32'hFFFF_FFF0, '0, '0, lat, rd, e);
        chk("io_ld", rd, 32'h0000_00A5);
        chk("io_no_en", en_cnt - en0, 0);

        // Misaligned load and out-of-range store
        en0 = en_cnt; we0 = we_cnt;
        txn(1'b1, 1'b0, 32'h13, '0, '0, lat, rd, e);
        chk("mis_lat", lat, 2);
        chk("mis_rd_err", {rd[30:0], e}, 32'h1);
        txn(1'b1, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, lat, rd, e);
        chk("unm_err", {31'h0, e}, 32'h1);
        txn(1'b0, 1'b0, 32'h11, '0, '0, lat, rd, e);
        chk("if_mis_err", {31'h0, e}, 32'h1);
        chk("bad_no_en", en_cnt - en0, 0);
        chk("bad_no_we", we_cnt - we0, 0);

        // Reset during ACCESS drops the store
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hCAFE_F00D; dm_be = 4'hF;
        tick();
        chk("abort_in_access", {31'h0, mem_en}, 32'h1);
        rst_n = 1'b0;
        dm1 = 0;
        tick();
        if (dm_ack) dm1 = 1;
        dm_req = 1'b0;
        tick();
        if (dm_ack) dm1 = 1;
        rst_n = 1'b1;
        chk("abort_no_ack", dm1, 0);
        chk("abort_io", mem_map_io, 32'h0);
        txn(1'b0, 1'b0, 32'h20, '0, '0, lat, rd, e);
        chk("abort_lat", lat, 2);
        chk("abort_no_wr", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
